// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its decoder neighbour.
package instr_fetch_unit_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam logic [OPCODE_W-1:0] OPCODE_BUBBLE = 7'b0000000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Opcodes the main control decoder recognises.
    localparam logic [OPCODE_W-1:0] OPC_LW    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_SW    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StKill  = 2'd2,
        StIssue = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PcHold   = 2'd0,
        PcInc    = 2'd1,
        PcTarget = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory port, redirect input and issue handshake.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [OPCODE_W-1:0]    opcode;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4,
        input  imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready
    );

    // Memory / execute / branch side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4,
        output imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// PC register with +4 adder, word alignment of redirect targets and next-PC select.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pc_sel_e               sel_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target_aligned;

    // Adder wraps naturally at 2^ADDR_WIDTH.
    assign pc_plus4_o     = pc_q + ADDR_WIDTH'(4);
    assign target_aligned = {target_i[ADDR_WIDTH-1:2], 2'b00};
    assign pc_o           = pc_q;

    // Select the next PC: hold, sequential advance or aligned redirect target.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PcInc:    pc_d = pc_plus4_o;
            PcTarget: pc_d = target_aligned;
            default:  pc_d = pc_q;
        endcase
    end

    // PC flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack and holds one instruction for issue.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    fetch_state_e           state_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   instr_valid_q;
    logic [ADDR_WIDTH-1:0]  pending_target_q;

    pc_sel_e               pc_sel;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sel_i      (pc_sel),
        .target_i   (pc_target),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    // Next-PC select; a same-cycle redirect always beats the stored pending target.
    always_comb begin
        pc_sel    = PcHold;
        pc_target = bus.redirect_target;
        unique case (state_q)
            StFetch: begin
                if (bus.imem_ack && bus.redirect_valid) pc_sel = PcTarget;
            end
            StKill: begin
                if (bus.imem_ack) begin
                    pc_sel = PcTarget;
                    if (!bus.redirect_valid) pc_target = pending_target_q;
                end
            end
            StIssue: begin
                if (bus.redirect_valid)   pc_sel = PcTarget;
                else if (bus.instr_ready) pc_sel = PcInc;
            end
            default: pc_sel = PcHold;
        endcase
    end

    // Fetch FSM with the held instruction and the pending redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            instr_q          <= '0;
            instr_valid_q    <= 1'b0;
            pending_target_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (bus.imem_ack && !bus.redirect_valid) begin
                        instr_q       <= bus.imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end else if (bus.redirect_valid && !bus.imem_ack) begin
                        // Request must stay on the old address until the memory acks it.
                        pending_target_q <= bus.redirect_target;
                        state_q          <= StKill;
                    end
                end
                StKill: begin
                    if (bus.redirect_valid) pending_target_q <= bus.redirect_target;
                    if (bus.imem_ack)       state_q          <= StFetch;
                end
                StIssue: begin
                    if (bus.redirect_valid || bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StFetch;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_req    = (state_q == StFetch) || (state_q == StKill);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_valid_q ? instr_q[OPCODE_W-1:0] : OPCODE_BUBBLE;
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory image used by the randomized phase: content is a hash of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Randomized-phase reference state.
    logic [31:0] exp_pc, prev_addr, w, tgt;
    logic        prev_req, prev_ack, prev_valid, redir, rdy;
    int          lat, wait_cnt, idle_cycles, deliveries;

    initial begin
        rst_n              = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.instr_ready    = 1'b0;
        #2;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_opcode", 32'(bus.opcode), 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pc4", bus.pc_plus4, 32'd4);
        chk("rst_instr", bus.instr, 32'd0);

        // Zero-wait memory, ready held: 2-cycle cadence at 0, 4, 8.
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("seq_req", 32'(bus.imem_req), 32'd1);
            chk("seq_addr", bus.imem_addr, 32'(4 * k));
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'h0050_0093;
            tick();
            bus.imem_ack = 1'b0;
            chk("seq_valid", 32'(bus.instr_valid), 32'd1);
            chk("seq_req_off", 32'(bus.imem_req), 32'd0);
            chk("seq_pc", bus.pc, 32'(4 * k));
            chk("seq_pc4", bus.pc_plus4, 32'(4 * k + 4));
            chk("seq_opcode", 32'(bus.opcode), 32'h13);
            tick();
        end

        // Stall in issue; acks while not requesting must be ignored.
        bus.instr_ready = 1'b0;
        chk("stall_addr", bus.imem_addr, 32'd12);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_2003;
        tick();
        bus.imem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_instr", bus.instr, 32'h0000_2003);
            chk("stall_pc", bus.pc, 32'd12);
            chk("stall_opcode", 32'(bus.opcode), 32'h03);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
            tick();
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("stall_next_addr", bus.imem_addr, 32'd16);

        // Redirect during a slow fetch: address held, data dropped, then target fetched.
        do_reset();
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        chk("kill_addr0", bus.imem_addr, 32'd0);
        chk("kill_req0", 32'(bus.imem_req), 32'd1);
        tick();
        chk("kill_addr1", bus.imem_addr, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("kill_valid", 32'(bus.instr_valid), 32'd0);
        chk("kill_opcode", 32'(bus.opcode), 32'd0);
        chk("kill_new_addr", bus.imem_addr, 32'h40);

        // Redirect together with ready in issue: target wins and is aligned.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        tick();
        bus.imem_ack = 1'b0;
        chk("iss_pc", bus.pc, 32'h40);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0102;
        bus.instr_ready     = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        chk("iss_redir_valid", 32'(bus.instr_valid), 32'd0);
        chk("iss_redir_addr", bus.imem_addr, 32'h100);

        // Redirect and ack in the same fetch cycle.
        bus.imem_ack        = 1'b1;
        bus.imem_rdata      = 32'h1234_5678;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0200;
        tick();
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("same_valid", 32'(bus.instr_valid), 32'd0);
        chk("same_addr", bus.imem_addr, 32'h200);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_2003;
        tick();
        bus.imem_ack = 1'b0;
        chk("same_deliver_pc", bus.pc, 32'h200);
        chk("same_deliver_instr", bus.instr, 32'h0000_2003);

        // PC wrap at the top of the address space.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_006F;
        tick();
        bus.imem_ack = 1'b0;
        chk("wrap_pc4", bus.pc_plus4, 32'd0);
        chk("wrap_opcode", 32'(bus.opcode), 32'h6F);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("wrap_next_addr", bus.imem_addr, 32'd0);
        chk("wrap_next_req", 32'(bus.imem_req), 32'd1);

        // Asynchronous reset in the middle of a wait.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_opcode", 32'(bus.opcode), 32'd0);
        chk("arst_pc", bus.pc, 32'd0);

        // Randomized traffic against a program-order model of the next delivered PC.
        do_reset();
        exp_pc      = 32'd0;
        prev_req    = 1'b0;
        prev_ack    = 1'b0;
        prev_valid  = 1'b0;
        prev_addr   = '0;
        lat         = 0;
        wait_cnt    = 0;
        idle_cycles = 0;
        deliveries  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_req && !prev_ack && bus.imem_req) begin
                chk("rnd_addr_stable", bus.imem_addr, prev_addr);
            end
            w = memword(exp_pc);
            if (bus.instr_valid && !prev_valid) begin
                chk("rnd_pc", bus.pc, exp_pc);
                chk("rnd_instr", bus.instr, w);
                chk("rnd_pc4", bus.pc_plus4, exp_pc + 32'd4);
                deliveries++;
                idle_cycles = 0;
            end else begin
                idle_cycles++;
            end
            chk("rnd_opcode", 32'(bus.opcode), bus.instr_valid ? 32'(w[6:0]) : 32'd0);
            if (idle_cycles > 200) begin
                chk("rnd_progress_timeout", 32'(idle_cycles), 32'd0);
                break;
            end

            redir = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            rdy   = ($urandom_range(0, 2) != 0);
            bus.redirect_valid  = redir;
            bus.redirect_target = tgt;
            bus.instr_ready     = rdy;
            if (bus.imem_req) begin
                if (wait_cnt >= lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = memword(bus.imem_addr);
                    lat            = $urandom_range(0, 3);
                    wait_cnt       = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.imem_ack   = ($urandom_range(0, 3) == 0);
                bus.imem_rdata = $urandom;
            end

            if (redir) exp_pc = {tgt[31:2], 2'b00};
            else if (bus.instr_valid && rdy) exp_pc = exp_pc + 32'd4;

            prev_req   = bus.imem_req;
            prev_ack   = bus.imem_ack;
            prev_addr  = bus.imem_addr;
            prev_valid = bus.instr_valid;
            tick();
        end
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rnd_some_deliveries", 32'(deliveries > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the RISC-V core; sits directly upstream of the main control decoder.
- Owns the PC register and fetches one 32-bit instruction per request over a req/ack instruction-memory port.
- Holds the fetched instruction until the execute side accepts it, and presents the opcode field to the decoder.
- Accepts PC redirects for taken beq and jal (PCSrc path), including redirects that arrive while a fetch is in flight.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  fetch address; word aligned.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- redirect_valid  in  1  taken branch/jump; load redirect_target.
- redirect_target  in  ADDR_WIDTH  new PC; bits [1:0] ignored, forced to 0.
- instr_valid  out  1  instr/pc outputs hold a live instruction.
- instr_ready  in  1  execute side consumes the held instruction this cycle.
- instr  out  INSTR_WIDTH  held instruction register.
- opcode  out  7  instr[6:0] when instr_valid, else 7'b0000000 (decoder default = bubble).
- pc  out  ADDR_WIDTH  address of the held instruction.
- pc_plus4  out  ADDR_WIDTH  pc + 4, modulo 2^ADDR_WIDTH; used for jal writeback.

Behaviour:
- States: IDLE, FETCH, KILL, ISSUE.
- Reset (async, rst_n=0) values:
  - state = IDLE, pc = RESET_PC, instr = 0, instr_valid = 0, pending_target = 0.
  - imem_req = 0, opcode = 0.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- imem_req = 1 in FETCH and KILL, else 0.
- imem_addr = pc. It must stay stable from request assertion until ack; it never changes while req=1 and ack=0.
- FETCH:
  - On imem_ack with no redirect: instr <= imem_rdata, instr_valid <= 1, go to ISSUE.
  - Latency is 1 cycle from ack to instr_valid; zero-wait memory gives 2 cycles per instruction.
- FETCH, redirect_valid without ack: pending_target <= target, go to KILL. The request stays on the old address.
- FETCH, redirect_valid with imem_ack in the same cycle: discard rdata, pc <= target, stay in FETCH.
- KILL:
  - Each new redirect overwrites pending_target (latest wins).
  - On imem_ack: discard rdata, pc <= pending_target (or the same-cycle redirect_target if redirect_valid=1), go to FETCH.
- ISSUE:
  - instr_ready=1, redirect_valid=0: pc <= pc+4, instr_valid <= 0, go to FETCH.
  - redirect_valid=1 (with or without instr_ready): pc <= target, instr_valid <= 0, go to FETCH. Redirect wins over sequential advance.
  - Neither asserted: hold everything; instr_valid stays 1.
- imem_ack outside FETCH/KILL is ignored.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset asserted mid-fetch returns to IDLE immediately.
  - The outstanding memory transaction is abandoned; memory must tolerate the req drop.

Decomposition:
- Shared package holds:
  - fetch state enum (IDLE=2'd0, FETCH=2'd1, KILL=2'd2, ISSUE=2'd3).
  - OPCODE_W=7 and OPCODE_BUBBLE=7'b0000000.
  - INSTR_NOP=32'h0000_0013.
  - opcode constants shared with the decoder (LW, SW, RTYPE, BEQ, ITYPE, JAL).
- One sub-module: fetch_pc_reg.
  - Contains the PC flop with RESET_PC, the +4 adder, target alignment, and the next-PC select (hold / +4 / target).
  - The FSM stays in the top level.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093, instr_ready held 1 -> imem_addr 0,4,8 at a 2-cycle cadence; opcode=7'b0010011 while valid; pc_plus4=pc+4.
- instr_ready held 0 for 5 cycles after a load of 32'h00002003 -> instr, pc and opcode=7'b0000011 stable; imem_req=0; no PC advance.
- Memory ack delayed 3 cycles; redirect_valid pulses to 32'h00000040 at cycle 1 of the wait -> imem_addr stays 0 until ack; rdata dropped, instr_valid stays 0; next imem_addr=32'h40.
- In ISSUE, assert redirect_valid (target 32'h00000102) and instr_ready together -> next imem_addr=32'h00000100; no fetch at pc+4.
- In FETCH, redirect and ack in the same cycle -> no instr_valid pulse; next request goes to the target address.
- With pc=32'hFFFF_FFFC, consume the instruction -> pc_plus4=0 and next imem_addr=0. Assert rst_n=0 mid-wait -> imem_req, instr_valid and opcode drop to 0 asynchronously; pc=RESET_PC.
